// File: rtl/rtc_fields_pkg.sv
// -----------------------------------------------------------------------------
// rtc_fields_pkg
// Shared definitions for the RTC/chronometer register bank write controller:
//   - bank addresses of every field (time, date, chronometer, cursor pointer)
//   - packed-BCD min/max bounds of each editable field
//   - edit sequencer state and edit direction enums
//   - field_range(): maps a bank address to its editable BCD range
// -----------------------------------------------------------------------------
package rtc_fields_pkg;

  // Bank addresses of the stored fields.
  localparam int unsigned FLD_SEG  = 1;   // seconds
  localparam int unsigned FLD_MIN  = 2;   // minutes
  localparam int unsigned FLD_HOR  = 3;   // hours
  localparam int unsigned FLD_DIA  = 4;   // day of month
  localparam int unsigned FLD_MES  = 5;   // month
  localparam int unsigned FLD_ANO  = 6;   // year
  localparam int unsigned FLD_CSEG = 9;   // chronometer seconds
  localparam int unsigned FLD_CMIN = 10;  // chronometer minutes
  localparam int unsigned FLD_CHOR = 11;  // chronometer hours
  localparam int unsigned FLD_PTR  = 12;  // cursor pointer (read-only here)

  // Packed 2-digit BCD bounds per field kind.
  localparam logic [7:0] SEG_LO = 8'h00;
  localparam logic [7:0] SEG_HI = 8'h59;
  localparam logic [7:0] MIN_LO = 8'h00;
  localparam logic [7:0] MIN_HI = 8'h59;
  localparam logic [7:0] HOR_LO = 8'h00;
  localparam logic [7:0] HOR_HI = 8'h23;
  localparam logic [7:0] DIA_LO = 8'h01;
  localparam logic [7:0] DIA_HI = 8'h31;
  localparam logic [7:0] MES_LO = 8'h01;
  localparam logic [7:0] MES_HI = 8'h12;
  localparam logic [7:0] ANO_LO = 8'h00;
  localparam logic [7:0] ANO_HI = 8'h99;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR       = 2'd3
  } edit_state_e;

  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } edit_dir_e;

  typedef struct packed {
    logic       editable;
    logic [7:0] lo;
    logic [7:0] hi;
  } field_range_t;

  // Chronometer fields share the bounds of their clock counterparts.
  function automatic field_range_t field_range(input int unsigned addr);
    field_range_t r;
    r = '{editable: 1'b0, lo: 8'h00, hi: 8'h00};
    case (addr)
      FLD_SEG, FLD_CSEG: r = '{editable: 1'b1, lo: SEG_LO, hi: SEG_HI};
      FLD_MIN, FLD_CMIN: r = '{editable: 1'b1, lo: MIN_LO, hi: MIN_HI};
      FLD_HOR, FLD_CHOR: r = '{editable: 1'b1, lo: HOR_LO, hi: HOR_HI};
      FLD_DIA:           r = '{editable: 1'b1, lo: DIA_LO, hi: DIA_HI};
      FLD_MES:           r = '{editable: 1'b1, lo: MES_LO, hi: MES_HI};
      FLD_ANO:           r = '{editable: 1'b1, lo: ANO_LO, hi: ANO_HI};
      default:           r = '{editable: 1'b0, lo: 8'h00, hi: 8'h00};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_step.sv
// -----------------------------------------------------------------------------
// bcd_step
// Combinational one-step increment/decrement of a packed 2-digit BCD value
// constrained to [min_val, max_val], wrapping at both ends.
// A value with a non-BCD nibble or outside the range is treated as corrupt:
// increment loads min_val, decrement loads max_val.
// Ports:
//   value   in  8  current field value (packed BCD)
//   min_val in  8  lowest legal value (packed BCD)
//   max_val in  8  highest legal value (packed BCD)
//   dir     in  -  DIR_INC or DIR_DEC
//   result  out 8  stepped value (packed BCD)
// -----------------------------------------------------------------------------
module bcd_step
  import rtc_fields_pkg::*;
(
  input  logic [7:0] value,
  input  logic [7:0] min_val,
  input  logic [7:0] max_val,
  input  edit_dir_e  dir,
  output logic [7:0] result
);

  logic digits_ok;
  logic in_range;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    digits_ok = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
    // With both digits legal, packed BCD orders exactly like its binary
    // encoding, so the bounds can be compared directly.
    in_range  = digits_ok && (value >= min_val) && (value <= max_val);
    result    = value;

    if (!in_range) begin
      result = (dir == DIR_INC) ? min_val : max_val;
    end else if (dir == DIR_INC) begin
      if (value == max_val)         result = min_val;
      else if (value[3:0] == 4'd9)  result = {value[7:4] + 4'd1, 4'd0};
      else                          result = value + 8'd1;
    end else begin
      if (value == min_val)         result = max_val;
      else if (value[3:0] == 4'd0)  result = {value[7:4] - 4'd1, 4'd9};
      else                          result = value - 8'd1;
    end
  end

endmodule

// File: rtl/rtc_mem_write_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_mem_write_ctrl
// Owner of the single write port of the 16x8 RTC/chronometer register bank.
// Arbitrates round-robin between
//   - the RTC read-back path (single-cycle field writes, request held until
//     granted), and
//   - the user edit path (read-modify-write BCD inc/dec of the field selected
//     by the cursor pointer: IDLE -> RD_ISSUE -> RD_WAIT -> WR).
// The cursor pointer address is never written; an RTC write aimed at it is
// granted but the strobe is suppressed.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rtc_req/addr/data   RTC write request
//   rtc_gnt             one-cycle grant, request consumed
//   edit_inc/edit_dec   one-cycle edit pulses
//   puntero             selected field address
//   mem_w/addr_w/data_w bank write port
//   mem_addr_rd         bank read address (bank output registered)
//   mem_data_rd         bank read data, valid the cycle after mem_addr_rd
//   busy                edit sequence in progress
//   edit_done           pulse with the edit write strobe
//   edit_err            pulse when an edit targets a non-editable address
// -----------------------------------------------------------------------------
module rtc_mem_write_ctrl
  import rtc_fields_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int PTR_ADDR = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rtc_req,
  input  logic [ADDR_W-1:0] rtc_addr,
  input  logic [DATA_W-1:0] rtc_data,
  output logic              rtc_gnt,
  input  logic              edit_inc,
  input  logic              edit_dec,
  input  logic [ADDR_W-1:0] puntero,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [DATA_W-1:0] mem_data_w,
  output logic [ADDR_W-1:0] mem_addr_rd,
  input  logic [DATA_W-1:0] mem_data_rd,
  output logic              busy,
  output logic              edit_done,
  output logic              edit_err
);

  edit_state_e       state;
  edit_state_e       state_nxt;
  logic              pending;     // captured edit waiting for the write port
  edit_dir_e         dir_q;
  logic [ADDR_W-1:0] field_q;
  logic              last_edit;   // last port grant went to the edit path
  logic [DATA_W-1:0] new_val;
  field_range_t      rng;
  logic [7:0]        step_result;

  logic edit_pulse;
  logic capture;
  logic rtc_win;
  logic edit_take;

  // Simultaneous inc and dec cancel out and are ignored.
  assign edit_pulse = edit_inc ^ edit_dec;
  // Only one edit is tracked; pulses while one is pending or running drop.
  assign capture    = (state == IDLE) && !pending && edit_pulse;
  // The RTC yields to a pending edit only if it held the port last.
  assign rtc_win    = (state == IDLE) && rtc_req && (!pending || last_edit);
  assign edit_take  = (state == IDLE) && pending && !rtc_win;

  assign rng  = field_range(32'(field_q));
  assign busy = (state != IDLE);

  bcd_step u_bcd_step (
    .value   (mem_data_rd[7:0]),
    .min_val (rng.lo),
    .max_val (rng.hi),
    .dir     (dir_q),
    .result  (step_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      dir_q     <= DIR_INC;
      field_q   <= '0;
      last_edit <= 1'b0;
      new_val   <= '0;
      edit_err  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      edit_err <= 1'b0;

      if (capture) begin
        pending <= 1'b1;
        dir_q   <= edit_inc ? DIR_INC : DIR_DEC;
        field_q <= puntero;
      end else if (edit_take) begin
        pending <= 1'b0;
      end

      if (rtc_win)        last_edit <= 1'b0;
      else if (edit_take) last_edit <= 1'b1;

      // A non-editable target is consumed here and reported next cycle.
      if (edit_take && !rng.editable) edit_err <= 1'b1;

      // Bank data is valid in RD_WAIT; hold the result for the WR strobe.
      if (state == RD_WAIT) new_val <= DATA_W'(step_result);
    end
  end

  always_comb begin
    state_nxt   = state;
    rtc_gnt     = 1'b0;
    mem_w       = 1'b0;
    mem_addr_w  = '0;
    mem_data_w  = '0;
    mem_addr_rd = '0;
    edit_done   = 1'b0;

    // NOTE: these outputs decode live inputs, so they are gated by reset
    // directly; otherwise a held rtc_req would grant while reset is asserted.
    if (!reset) begin
      case (state)
        IDLE: begin
          if (rtc_win) begin
            rtc_gnt = 1'b1;
            if (rtc_addr != ADDR_W'(PTR_ADDR)) begin
              mem_w      = 1'b1;
              mem_addr_w = rtc_addr;
              mem_data_w = rtc_data;
            end
          end else if (edit_take && rng.editable) begin
            state_nxt = RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          mem_addr_rd = field_q;
          state_nxt   = RD_WAIT;
        end
        RD_WAIT: begin
          state_nxt = WR;
        end
        WR: begin
          mem_w      = 1'b1;
          mem_addr_w = field_q;
          mem_data_w = new_val;
          edit_done  = 1'b1;
          state_nxt  = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rtc_mem_write_ctrl.md
Name: rtc_mem_write_ctrl

Overview:
- Sequencer and arbiter for the single write port of the 16x8 RTC/chronometer register bank.
- Serves two requesters:
  - RTC read-back path: single-cycle field writes.
  - User edit path: read-modify-write BCD increment/decrement of the field selected by the cursor pointer.
- Sits between the RTC bus FSM, the keypad/button decoder and the register bank. It drives the bank's write port and one read port.

Parameters:
- ADDR_W, 4, bank address width.
- DATA_W, 8, bank data width; fields stored as packed 2-digit BCD.
- PTR_ADDR, 12, bank address holding the cursor pointer; never written by this block.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rtc_req  in  1  RTC path requests a write; held until granted
- rtc_addr  in  ADDR_W  RTC write address
- rtc_data  in  DATA_W  RTC write data (BCD)
- rtc_gnt  out  1  one-cycle pulse; request consumed this cycle
- edit_inc  in  1  one-cycle pulse: increment selected field
- edit_dec  in  1  one-cycle pulse: decrement selected field
- puntero  in  ADDR_W  selected field address
- mem_w  out  1  bank write enable
- mem_addr_w  out  ADDR_W  bank write address
- mem_data_w  out  DATA_W  bank write data
- mem_addr_rd  out  ADDR_W  bank read address (bank output is registered)
- mem_data_rd  in  DATA_W  bank read data, valid the cycle after mem_addr_rd is sampled
- busy  out  1  edit in progress (state not IDLE)
- edit_done  out  1  one-cycle pulse when an edit write is issued
- edit_err  out  1  one-cycle pulse when an edit targets a non-editable address

Behaviour:
- Reset (async, active-high): all outputs 0, pending edit cleared, FSM in IDLE.
- Edit capture:
  - An edit_inc or edit_dec pulse sets a single pending bit, latching direction and puntero.
  - Pulses arriving while an edit is pending or busy are dropped.
  - edit_inc and edit_dec in the same cycle: no-op, nothing latched.
- Editable fields and BCD ranges:
  - 1 sec 00-59; 2 min 00-59; 3 hr 00-23; 4 day 01-31; 5 month 01-12; 6 year 00-99.
  - 9 chrono sec 00-59; 10 chrono min 00-59; 11 chrono hr 00-23.
  - Any other address: edit_err pulses in the cycle after acceptance, pending cleared, no bank access.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR.
  - IDLE, rtc_req high, and (no pending edit or last grant was an edit): rtc_gnt=1, mem_w=1, mem_addr_w=rtc_addr, mem_data_w=rtc_data for one cycle. Stay in IDLE.
  - IDLE, pending edit with valid address, and RTC not granted: go to RD_ISSUE and clear pending.
  - Arbitration: round-robin between RTC and edit; a pending edit never waits more than one RTC grant.
  - RD_ISSUE: mem_addr_rd=latched field. Next state RD_WAIT.
  - RD_WAIT: mem_data_rd is valid; compute the new value. Next state WR.
  - WR: mem_w=1, mem_addr_w=field, mem_data_w=new value, edit_done=1. Next state IDLE.
- Edit latency: acceptance in IDLE at cycle N; write strobe at cycle N+3.
- rtc_gnt is held 0 outside IDLE; rtc_req stays asserted until granted.
- RTC write with rtc_addr==PTR_ADDR: rtc_gnt pulses but mem_w stays 0 (write suppressed).
- BCD arithmetic:
  - inc at max wraps to min; dec at min wraps to max.
  - Read value outside range or containing a non-BCD nibble: inc loads min, dec loads max.
  - Digit carry/borrow: 09+1=10, 10-1=09.
- mem_w is never asserted for two sources in one cycle. mem_w is 0 in every state except the RTC-grant cycle and WR.
- Reset asserted mid-edit: edit aborted with no write; outputs forced to 0 immediately (async).

Decomposition:
- Package rtc_fields_pkg:
  - field address constants (SEG=1, MIN=2, HOR=3, DIA=4, MES=5, ANO=6, CSEG=9, CMIN=10, CHOR=11, PTR=12);
  - per-field BCD min/max constants;
  - FSM state enum.
- Sub-module bcd_step (combinational): inputs value, min, max, dir; output next BCD value with wrap and invalid-input handling. Instantiated once.

Test Plan:
- Edit wrap: bank[2]=8'h59, puntero=2, edit_inc pulse -> mem_w in cycle N+3 with addr 2, data 8'h00; edit_done pulse in the same cycle.
- Lower bound: bank[5]=8'h01, edit_dec, puntero=5 -> write 8'h12. Then bank[4]=8'h31, edit_inc, puntero=4 -> write 8'h01.
- Invalid/non-editable input: bank[3]=8'h3A, edit_inc, puntero=3 -> write 8'h00. Then puntero=7, edit_dec -> edit_err pulse, mem_w never asserted.
- Contention: rtc_req held (addr 1, data 8'h45) in the same cycle as edit_inc, puntero=9 -> rtc_gnt and write 1/0x45 first. Edit starts the next cycle. rtc_req re-asserted during the edit -> granted only after WR.
- Pointer protection and filtering: rtc_req addr 12 data 8'hFF -> rtc_gnt=1, mem_w=0. edit_inc and edit_dec in the same cycle -> no activity, busy stays 0.
- Reset mid-edit: reset asserted during RD_WAIT -> mem_w, busy and rtc_gnt drop to 0 asynchronously; no write after reset is released.
